// File: rtl/quad_encoder_decoder.sv
// Quadrature encoder front end: sync, glitch filter, 4x decode, velocity.
// Optional index channel enabled by defining QUAD_ENCODER_INDEX_EN.
module quad_encoder_decoder #(
  parameter int POS_W         = 16,
  parameter int VEL_W         = 12,
  parameter int FILT_LEN      = 3,
  parameter int WINDOW_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             encoder_a,
  input  logic             encoder_b,
  input  logic             encoder_z,
  input  logic             clear_pos,
  input  logic             err_clr,
  output logic [POS_W-1:0] position,
  output logic [VEL_W-1:0] velocity,
  output logic             vel_valid,
  output logic             direction,
  output logic             step_pulse,
  output logic             quad_error,
  output logic             index_seen
);
`ifdef QUAD_ENCODER_INDEX_EN
  localparam int NCH = 3;
`else
  localparam int NCH = 2;
`endif
  localparam int WC_W   = $clog2(WINDOW_CYCLES);
  localparam int AW     = VEL_W + 1;
  localparam int STAB_N = FILT_LEN + 2;
  localparam int AMAX_I = 2**(AW-1) - 1;
  localparam int AMIN_I = -(2**(AW-1));
  localparam int VMAX_I = 2**(VEL_W-1) - 1;
  localparam int VMIN_I = -(2**(VEL_W-1));
  localparam logic signed [AW:0] AMAX = (AW+1)'(AMAX_I);
  localparam logic signed [AW:0] AMIN = (AW+1)'(AMIN_I);
  localparam logic signed [AW:0] VMAX = (AW+1)'(VMAX_I);
  localparam logic signed [AW:0] VMIN = (AW+1)'(VMIN_I);

  typedef enum logic {INIT, RUN} state_e;

  logic [NCH-1:0] raw, s1_q, s2_q, f_q, f_d;
  logic [3:0] cnt_q [NCH];
  logic [3:0] cnt_d [NCH];
  state_e state_q, state_d;
  logic [4:0] stab_q, stab_d;
  logic [1:0] ab, prev_q, prev_d;
  logic [1:0] g_cur, g_prev, g_diff;
  logic stable, load, step, fwd, illegal, idx_rise;
  logic [POS_W-1:0] pos_q, pos_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [AW:0] delta, sum, acc_sat, vel_sat;
  logic [VEL_W-1:0] vel_q, vel_d;
  logic [WC_W-1:0] win_q, win_d;
  logic win_tc, vv_q, dir_q, dir_d, pulse_q, err_q, err_d;

`ifdef QUAD_ENCODER_INDEX_EN
  logic zprev_q, idx_q;
  assign raw = {encoder_z, encoder_b, encoder_a};
  assign idx_rise = (state_q == RUN) && f_q[2] && !zprev_q;
  assign index_seen = idx_q;

  // Z edge history and sticky index flag (set beats err_clr)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zprev_q <= 1'b0;
      idx_q   <= 1'b0;
    end else begin
      zprev_q <= f_q[2];
      idx_q   <= idx_rise ? 1'b1 : (err_clr ? 1'b0 : idx_q);
    end
  end
`else
  logic z_unused;
  assign z_unused = encoder_z;
  assign raw = {encoder_b, encoder_a};
  assign idx_rise = 1'b0;
  assign index_seen = 1'b0;
`endif

  // Accept a channel change only after FILT_LEN differing samples
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      f_d[i]   = f_q[i];
      cnt_d[i] = '0;
      if (s2_q[i] != f_q[i]) begin
        if (cnt_q[i] + 4'd1 == 4'(FILT_LEN)) f_d[i] = s2_q[i];
        else cnt_d[i] = cnt_q[i] + 4'd1;
      end
    end
  end

  // Two-flop synchronisers and filter state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= '0;
      s2_q <= '0;
      f_q  <= '0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      f_q  <= f_d;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // INIT waits for the whole sync+filter path to settle so
  // the post-reset state is loaded, never counted
  assign stable = (s1_q[1:0] == f_q[1:0]) && (s2_q[1:0] == f_q[1:0]);
  always_comb begin
    state_d = state_q;
    stab_d  = '0;
    load    = 1'b0;
    unique case (state_q)
      INIT: begin
        if (stable) begin
          stab_d = stab_q + 5'd1;
          if (stab_q == 5'(STAB_N - 1)) begin
            state_d = RUN;
            load    = 1'b1;
          end
        end
      end
      RUN: state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // Gray position difference classifies the transition
  assign ab     = {f_q[0], f_q[1]};
  assign g_cur  = {ab[1], ab[1] ^ ab[0]};
  assign g_prev = {prev_q[1], prev_q[1] ^ prev_q[0]};
  assign g_diff = g_cur - g_prev;
  always_comb begin
    step    = 1'b0;
    fwd     = 1'b0;
    illegal = 1'b0;
    prev_d  = (load || state_q == RUN) ? ab : prev_q;
    if (state_q == RUN && ab != prev_q) begin
      unique case (1'b1)
        (g_diff == 2'd1): begin step = 1'b1; fwd = 1'b1; end
        (g_diff == 2'd3): step = 1'b1;
        default: illegal = 1'b1;
      endcase
    end
  end

  // Position, flags, saturating velocity accumulator, window
  assign win_tc = (win_q == WC_W'(WINDOW_CYCLES - 1));
  always_comb begin
    pos_d = pos_q;
    if (idx_rise || clear_pos) pos_d = '0;
    else if (step) pos_d = fwd ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
    dir_d = step ? fwd : dir_q;
    err_d = illegal ? 1'b1 : (err_clr ? 1'b0 : err_q);
    delta = step ? (fwd ? (AW+1)'(1) : '1) : '0;
    sum   = {acc_q[AW-1], acc_q} + delta;
    acc_sat = (sum > AMAX) ? AMAX : ((sum < AMIN) ? AMIN : sum);
    vel_sat = (acc_sat > VMAX) ? VMAX : ((acc_sat < VMIN) ? VMIN : acc_sat);
    vel_d = vel_q;
    acc_d = acc_sat[AW-1:0];
    win_d = win_q + WC_W'(1);
    if (win_tc) begin
      vel_d = vel_sat[VEL_W-1:0];
      acc_d = '0;
      win_d = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INIT;
      stab_q  <= '0;
      prev_q  <= '0;
      pos_q   <= '0;
      acc_q   <= '0;
      vel_q   <= '0;
      vv_q    <= 1'b0;
      win_q   <= '0;
      dir_q   <= 1'b0;
      pulse_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
      prev_q  <= prev_d;
      pos_q   <= pos_d;
      acc_q   <= acc_d;
      vel_q   <= vel_d;
      vv_q    <= win_tc;
      win_q   <= win_d;
      dir_q   <= dir_d;
      pulse_q <= step;
      err_q   <= err_d;
    end
  end

  assign position   = pos_q;
  assign velocity   = vel_q;
  assign vel_valid  = vv_q;
  assign direction  = dir_q;
  assign step_pulse = pulse_q;
  assign quad_error = err_q;
endmodule

// File: tb/tb_quad_encoder_decoder.sv
// Randomised bench for quad_encoder_decoder against an event-level model.
// Two instances: default widths and a narrow one for wrap/saturation.
module tb_quad_encoder_decoder;
  localparam int FL = 3, WIN = 100, LAT = FL + 3;
  localparam int PW = 16, VW = 12, PWS = 8, VWS = 4;
  localparam int MAXE = 32768;
`ifdef QUAD_ENCODER_INDEX_EN
  localparam bit IDX = 1'b1;
`else
  localparam bit IDX = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0;
  logic a = 1'b1, b = 1'b1, z = 1'b0, clr = 1'b0, eclr = 1'b0;
  logic [PW-1:0] pos;
  logic [VW-1:0] vel;
  logic vv, dir, pulse, err, idx;
  logic [PWS-1:0] pos_s;
  logic [VWS-1:0] vel_s;
  logic vv_s, dir_s, pulse_s, err_s, idx_s;

  quad_encoder_decoder #(.POS_W(PW), .VEL_W(VW), .FILT_LEN(FL),
    .WINDOW_CYCLES(WIN)) dut (
    .clk(clk), .rst(rst), .encoder_a(a), .encoder_b(b),
    .encoder_z(z), .clear_pos(clr), .err_clr(eclr),
    .position(pos), .velocity(vel), .vel_valid(vv),
    .direction(dir), .step_pulse(pulse), .quad_error(err),
    .index_seen(idx));

  quad_encoder_decoder #(.POS_W(PWS), .VEL_W(VWS), .FILT_LEN(FL),
    .WINDOW_CYCLES(WIN)) dut_s (
    .clk(clk), .rst(rst), .encoder_a(a), .encoder_b(b),
    .encoder_z(z), .clear_pos(clr), .err_clr(eclr),
    .position(pos_s), .velocity(vel_s), .vel_valid(vv_s),
    .direction(dir_s), .step_pulse(pulse_s), .quad_error(err_s),
    .index_seen(idx_s));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, en = 0, gi = 2, n_pulse = 0;
  bit rnd_en = 1'b0;
  logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int  ev_step [MAXE];
  bit  ev_clr [MAXE];
  bit  ev_eclr [MAXE];
  bit  ev_z [MAXE];
  int  m_pos, acc_b, acc_s, m_vel_b, m_vel_s;
  bit  m_pulse, m_dir, m_err, m_idx, m_vv;
  int  last_vel_b, last_vel_s;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)",
               tag, got, exp, en);
    end
  endtask

  function automatic int sat(int v, int lo, int hi);
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  task automatic model_edge(int e);
    int k, d;
    bit st;
    k = e % MAXE;
    d = ev_step[k];
    st = (d == 1) || (d == -1);
    m_pulse = st;
    if (st) m_dir = (d == 1);
    if (ev_z[k] || ev_clr[k]) m_pos = 0;
    else if (st) m_pos = m_pos + d;
    if (d == 2) m_err = 1'b1;
    else if (ev_eclr[k]) m_err = 1'b0;
    if (ev_z[k]) m_idx = 1'b1;
    else if (ev_eclr[k]) m_idx = 1'b0;
    if (st) begin
      acc_b = sat(acc_b + d, -(1 << VW), (1 << VW) - 1);
      acc_s = sat(acc_s + d, -(1 << VWS), (1 << VWS) - 1);
    end
    m_vv = (e % WIN == 0);
    if (m_vv) begin
      m_vel_b = sat(acc_b, -(1 << (VW-1)), (1 << (VW-1)) - 1);
      m_vel_s = sat(acc_s, -(1 << (VWS-1)), (1 << (VWS-1)) - 1);
      acc_b = 0;
      acc_s = 0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) begin
      en++;
      model_edge(en);
    end
    @(negedge clk);
    check("pos", 32'(pos), m_pos & ((1 << PW) - 1));
    check("pos_s", 32'(pos_s), m_pos & ((1 << PWS) - 1));
    check("pulse", 32'(pulse), 32'(m_pulse));
    check("dir", 32'(dir), 32'(m_dir));
    check("err", 32'(err), 32'(m_err));
    check("idx", 32'(idx), 32'(m_idx));
    check("vv", 32'(vv), 32'(m_vv));
    check("vv_s", 32'(vv_s), 32'(m_vv));
    check("vel", 32'(vel), m_vel_b & ((1 << VW) - 1));
    check("vel_s", 32'(vel_s), m_vel_s & ((1 << VWS) - 1));
    if (pulse) n_pulse++;
    if (vv) begin
      last_vel_b = 32'(vel);
      last_vel_s = 32'(vel_s);
    end
    clr  = 1'b0;
    eclr = 1'b0;
  endtask

  task automatic do_reset();
    rst  = 1'b0;
    clr  = 1'b0;
    eclr = 1'b0;
    for (int i = 0; i < MAXE; i++) begin
      ev_step[i] = 0;
      ev_clr[i]  = 1'b0;
      ev_eclr[i] = 1'b0;
      ev_z[i]    = 1'b0;
    end
    en = 0; m_pos = 0; acc_b = 0; acc_s = 0;
    m_vel_b = 0; m_vel_s = 0;
    m_pulse = 0; m_dir = 0; m_err = 0; m_idx = 0; m_vv = 0;
    repeat (3) cyc();
    rst = 1'b1;
    repeat (20) cyc();
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    ev_clr[(en + 1) % MAXE] = 1'b1;
    cyc();
  endtask

  task automatic pulse_eclr();
    eclr = 1'b1;
    ev_eclr[(en + 1) % MAXE] = 1'b1;
    cyc();
  endtask

  // kind: 1 forward, -1 reverse, 2 both bits flip
  task automatic move(int kind, int hold, int clr_off);
    gi = (gi + ((kind == 1) ? 1 : ((kind == -1) ? 3 : 2))) % 4;
    {a, b} = seq[gi];
    ev_step[(en + LAT) % MAXE] = kind;
    for (int i = 0; i < hold; i++) begin
      if (i == clr_off) begin
        clr = 1'b1;
        ev_clr[(en + 1) % MAXE] = 1'b1;
      end else if (rnd_en) begin
        if ($urandom_range(0, 19) == 0) begin
          clr = 1'b1;
          ev_clr[(en + 1) % MAXE] = 1'b1;
        end
        if ($urandom_range(0, 24) == 0) begin
          eclr = 1'b1;
          ev_eclr[(en + 1) % MAXE] = 1'b1;
        end
      end
      cyc();
    end
  endtask

  task automatic glitch(bit on_b, int w);
    if (on_b) b = ~b; else a = ~a;
    repeat (w) cyc();
    if (on_b) b = ~b; else a = ~a;
    repeat (4) cyc();
  endtask

  task automatic z_pulse();
    z = 1'b1;
    if (IDX) ev_z[(en + LAT) % MAXE] = 1'b1;
    repeat (5) cyc();
    z = 1'b0;
    repeat (8) cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int r;
    do_reset();
    check("init_pos", 32'(pos), 32'd0);
    check("init_err", 32'(err), 32'd0);
    check("init_pulses", 32'(n_pulse), 32'd0);

    n_pulse = 0;
    repeat (12) move(1, 10, -1);
    check("fwd_pos", 32'(pos), 32'd12);
    check("fwd_dir", 32'(dir), 32'd1);
    check("fwd_pulses", 32'(n_pulse), 32'd12);

    glitch(1'b0, 1);
    glitch(1'b1, 2);
    check("glitch_pos", 32'(pos), 32'd12);
    check("glitch_err", 32'(err), 32'd0);

    move(1, 10, -1);
    move(1, 10, -1);
    move(2, 10, -1);
    check("illegal_err", 32'(err), 32'd1);
    check("illegal_pos", 32'(pos), 32'd14);
    pulse_eclr();
    repeat (2) cyc();
    check("eclr_err", 32'(err), 32'd0);

    repeat (125) move(-1, 4, -1);
    check("vel_rev", 32'(last_vel_b), 32'hFE7);
    check("vel_rev_s", 32'(last_vel_s), 32'h8);
    repeat (100) move(1, 5, -1);
    check("vel_fwd", 32'(last_vel_b), 32'd20);
    check("vel_sat_s", 32'(last_vel_s), 32'd7);

    do_reset();
    check("rerst_pos", 32'(pos), 32'd0);
    repeat (127) move(1, 4, -1);
    repeat (4) cyc();
    check("wrap_pre", 32'(pos_s), 32'h7F);
    move(1, 10, -1);
    check("wrap_80", 32'(pos_s), 32'h80);
    move(1, 10, -1);
    check("wrap_81", 32'(pos_s), 32'h81);
    check("wrap_big", 32'(pos), 32'd129);
    n_pulse = 0;
    move(1, 10, LAT - 1);
    check("clr_step_pos", 32'(pos), 32'd0);
    check("clr_step_pulse", 32'(n_pulse), 32'd1);

    pulse_clr();
    repeat (37) move(1, 4, -1);
    repeat (4) cyc();
    check("pre_z_pos", 32'(pos), 32'd37);
    z_pulse();
    check("z_pos", 32'(pos), IDX ? 32'd0 : 32'd37);
    check("z_seen", 32'(idx), 32'(IDX));

    rnd_en = 1'b1;
    repeat (150) begin
      r = $urandom_range(0, 99);
      if (r < 45) move(1, $urandom_range(4, 12), -1);
      else if (r < 90) move(-1, $urandom_range(4, 12), -1);
      else if (r < 95) move(2, $urandom_range(4, 12), -1);
      else z_pulse();
      if ($urandom_range(0, 7) == 0)
        glitch(1'($urandom_range(0, 1)), $urandom_range(1, FL - 1));
    end
    rnd_en = 1'b0;
    repeat (10) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
